// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM scheduler: command word layout,
// command FSM state encoding and the pulse-width clamp.
package servo_pkg;

  localparam int unsigned CMD_W      = 16;
  localparam int unsigned CMD_CH_MSB = 15;
  localparam int unsigned CMD_CH_LSB = 12;
  localparam int unsigned CMD_W_MSB  = 11;
  localparam int unsigned CMD_W_LSB  = 0;
  localparam int unsigned CH_W       = CMD_CH_MSB - CMD_CH_LSB + 1;
  localparam int unsigned WIDTH_W    = CMD_W_MSB - CMD_W_LSB + 1;
  localparam int unsigned BAD_CNT_W  = 8;

  typedef enum logic {
    CMD_WAIT = 1'b0,
    CMD_ACK  = 1'b1
  } cmd_state_e;

  // Zero passes through (channel disabled); anything else is forced into range.
  function automatic logic [WIDTH_W-1:0] clamp_width(
    input logic [WIDTH_W-1:0] w,
    input logic [WIDTH_W-1:0] min_p,
    input logic [WIDTH_W-1:0] max_p
  );
    logic [WIDTH_W-1:0] r;
    r = w;
    if (w == '0) begin
      r = '0;
    end else if (w < min_p) begin
      r = min_p;
    end else if (w > max_p) begin
      r = max_p;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_scheduler_if.sv
// stb/ack command stream carrying 16-bit servo command words.
interface servo_pwm_scheduler_if;
  import servo_pkg::*;

  logic [CMD_W-1:0] servos;
  logic             servos_stb;
  logic             servos_ack;

  modport master (output servos, output servos_stb, input  servos_ack);
  modport slave  (input  servos, input  servos_stb, output servos_ack);
endinterface

// File: rtl/servo_cmd_rx.sv
// Command receiver: stb/ack handshake, channel/width decode with clamping,
// and a saturating counter of commands addressed to non-existent channels.
module servo_cmd_rx
  import servo_pkg::*;
#(
  parameter int unsigned NUM_SERVOS = 8,
  parameter int unsigned MIN_PULSE  = 500,
  parameter int unsigned MAX_PULSE  = 2500
) (
  input  logic                 clk,
  input  logic                 rst,
  servo_pwm_scheduler_if.slave cmd,
  output logic                 wr_en,
  output logic [CH_W-1:0]      wr_ch,
  output logic [WIDTH_W-1:0]   wr_width,
  output logic [BAD_CNT_W-1:0] bad_cmd_count
);

  cmd_state_e           state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 wr_en_q, wr_en_d;
  logic [CH_W-1:0]      wr_ch_q, wr_ch_d;
  logic [WIDTH_W-1:0]   wr_width_q, wr_width_d;
  logic [BAD_CNT_W-1:0] bad_q, bad_d;
  logic [CH_W-1:0]      ch_c;
  logic [WIDTH_W-1:0]   width_c;

  assign ch_c    = cmd.servos[CMD_CH_MSB:CMD_CH_LSB];
  assign width_c = cmd.servos[CMD_W_MSB:CMD_W_LSB];

  // Capture and decode in CMD_WAIT so ack and the shadow write strobe are
  // both registered and coincide with the CMD_ACK cycle.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    wr_en_d    = 1'b0;
    wr_ch_d    = wr_ch_q;
    wr_width_d = wr_width_q;
    bad_d      = bad_q;
    case (state_q)
      CMD_WAIT: begin
        if (cmd.servos_stb) begin
          state_d = CMD_ACK;
          ack_d   = 1'b1;
          if (32'(ch_c) < NUM_SERVOS) begin
            wr_en_d    = 1'b1;
            wr_ch_d    = ch_c;
            wr_width_d = clamp_width(width_c, WIDTH_W'(MIN_PULSE), WIDTH_W'(MAX_PULSE));
          end else if (bad_q != '1) begin
            bad_d = bad_q + BAD_CNT_W'(1);
          end
        end
      end
      CMD_ACK: begin
        state_d = CMD_WAIT;
      end
      default: begin
        state_d = CMD_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CMD_WAIT;
      ack_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_ch_q    <= '0;
      wr_width_q <= '0;
      bad_q      <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      wr_en_q    <= wr_en_d;
      wr_ch_q    <= wr_ch_d;
      wr_width_q <= wr_width_d;
      bad_q      <= bad_d;
    end
  end

  assign cmd.servos_ack = ack_q;
  assign wr_en          = wr_en_q;
  assign wr_ch          = wr_ch_q;
  assign wr_width       = wr_width_q;
  assign bad_cmd_count  = bad_q;

endmodule

// File: rtl/servo_pwm_scheduler.sv
// Multi-channel servo PWM generator sharing one frame timer; widths are
// double-buffered and take effect at frame boundaries. SERVO_STAGGER_EN
// offsets each channel's pulse start by k*STAGGER_TICKS.
module servo_pwm_scheduler
  import servo_pkg::*;
#(
  parameter int unsigned NUM_SERVOS    = 8,
  parameter int unsigned TICK_DIV      = 100,
  parameter int unsigned FRAME_TICKS   = 20000,
  parameter int unsigned MIN_PULSE     = 500,
  parameter int unsigned MAX_PULSE     = 2500,
  parameter int unsigned STAGGER_TICKS = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  servo_pwm_scheduler_if.slave  cmd,
  output logic [NUM_SERVOS-1:0] pwm,
  output logic                  frame_start,
  output logic [BAD_CNT_W-1:0]  bad_cmd_count
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

`ifdef SERVO_STAGGER_EN
  if ((NUM_SERVOS - 1) * STAGGER_TICKS + MAX_PULSE > FRAME_TICKS) begin : g_stagger_cfg_err
    $error("servo_pwm_scheduler: staggered pulses do not fit in one frame");
  end
`endif

  logic                  wr_en;
  logic [CH_W-1:0]       wr_ch;
  logic [WIDTH_W-1:0]    wr_width;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic                  frame_start_q, frame_start_d;
  logic [NUM_SERVOS-1:0] pwm_q, pwm_d;
  logic [WIDTH_W-1:0]    shadow_q [NUM_SERVOS];
  logic [WIDTH_W-1:0]    shadow_d [NUM_SERVOS];
  logic [WIDTH_W-1:0]    active_q [NUM_SERVOS];
  logic [WIDTH_W-1:0]    active_d [NUM_SERVOS];
  logic                  presc_wrap_c;
  logic                  boundary_c;
`ifdef SERVO_STAGGER_EN
  logic [31:0]           start_c;
`endif

  servo_cmd_rx #(
    .NUM_SERVOS (NUM_SERVOS),
    .MIN_PULSE  (MIN_PULSE),
    .MAX_PULSE  (MAX_PULSE)
  ) u_cmd_rx (
    .clk           (clk),
    .rst           (rst),
    .cmd           (cmd),
    .wr_en         (wr_en),
    .wr_ch         (wr_ch),
    .wr_width      (wr_width),
    .bad_cmd_count (bad_cmd_count)
  );

  // Shared prescaler and frame tick counter.
  always_comb begin
    presc_wrap_c  = (presc_q == PRESC_W'(TICK_DIV - 1));
    presc_d       = presc_wrap_c ? '0 : presc_q + PRESC_W'(1);
    tick_d        = tick_q;
    if (presc_wrap_c) begin
      tick_d = (tick_q == TICK_W'(FRAME_TICKS - 1)) ? '0 : tick_q + TICK_W'(1);
    end
    boundary_c    = (presc_q == '0) && (tick_q == '0);
    frame_start_d = (presc_d == '0) && (tick_d == '0);
  end

  // Shadow takes command writes; active reloads from the pre-edge shadow at
  // the boundary, so a write landing on that same edge waits a frame.
  always_comb begin
    for (int unsigned k = 0; k < NUM_SERVOS; k++) begin
      shadow_d[k] = shadow_q[k];
      if (wr_en && (wr_ch == CH_W'(k))) begin
        shadow_d[k] = wr_width;
      end
      active_d[k] = boundary_c ? shadow_q[k] : active_q[k];
    end
  end

  // Comparing against the post-reload width keeps the high time exact in
  // the first frame after an update.
  always_comb begin
    pwm_d = '0;
`ifdef SERVO_STAGGER_EN
    start_c = '0;
`endif
    for (int unsigned k = 0; k < NUM_SERVOS; k++) begin
`ifdef SERVO_STAGGER_EN
      start_c  = 32'(k * STAGGER_TICKS);
      pwm_d[k] = (active_d[k] != '0) &&
                 (32'(tick_q) >= start_c) &&
                 (32'(tick_q) < start_c + 32'(active_d[k]));
`else
      pwm_d[k] = (active_d[k] != '0) && (32'(tick_q) < 32'(active_d[k]));
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q       <= '0;
      tick_q        <= '0;
      frame_start_q <= 1'b0;
      pwm_q         <= '0;
      for (int unsigned k = 0; k < NUM_SERVOS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      frame_start_q <= frame_start_d;
      pwm_q         <= pwm_d;
      for (int unsigned k = 0; k < NUM_SERVOS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
    end
  end

  assign pwm         = pwm_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// Directed self-checking bench for servo_pwm_scheduler (small timing
// parameters; stagger scenario only when SERVO_STAGGER_EN is defined).
module tb_servo_pwm_scheduler;

  localparam int unsigned NS   = 4;
  localparam int unsigned TD   = 2;
  localparam int unsigned FT   = 100;
  localparam int unsigned MINP = 10;
  localparam int unsigned STG  = 20;
`ifdef SERVO_STAGGER_EN
  localparam int unsigned MAXP = 40;
  localparam int unsigned OFS  = STG;
`else
  localparam int unsigned MAXP = 50;
  localparam int unsigned OFS  = 0;
`endif
  localparam int unsigned FRAME_CYC = TD * FT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] pwm;
  logic          frame_start;
  logic [7:0]    bad_cmd_count;

  int checks   = 0;
  int failures = 0;
  int m_first [NS];
  int m_cnt   [NS];
  int m_fs;
  int m_overlap;

  servo_pwm_scheduler_if bus ();

  servo_pwm_scheduler #(
    .NUM_SERVOS    (NS),
    .TICK_DIV      (TD),
    .FRAME_TICKS   (FT),
    .MIN_PULSE     (MINP),
    .MAX_PULSE     (MAXP),
    .STAGGER_TICKS (STG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd           (bus),
    .pwm           (pwm),
    .frame_start   (frame_start),
    .bad_cmd_count (bad_cmd_count)
  );

  always #5 clk = ~clk;

  task automatic send_cmd(input logic [15:0] c, input string name);
    int lat;
    lat = 0;
    repeat (2) @(negedge clk);
    bus.servos     = c;
    bus.servos_stb = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bus.servos_ack === 1'b1) begin
        lat = i;
        break;
      end
    end
    bus.servos_stb = 1'b0;
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL %s ack_latency got=%0d exp=1", name, lat);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.servos_ack !== 1'b0) begin
      failures++;
      $display("FAIL %s ack_one_cycle got=%b exp=0", name, bus.servos_ack);
    end
  endtask

  task automatic wait_fs();
    bit found;
    found = 1'b0;
    for (int i = 0; i < int'(FRAME_CYC) + 50; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL frame_sync got=timeout exp=frame_start");
    end
  endtask

  // Records one frame of pwm, starting from the frame_start cycle as index 0.
  task automatic measure(input bit do_wait);
    if (do_wait) wait_fs();
    for (int k = 0; k < int'(NS); k++) begin
      m_first[k] = -1;
      m_cnt[k]   = 0;
    end
    m_fs      = 0;
    m_overlap = 0;
    for (int i = 0; i < int'(FRAME_CYC); i++) begin
      if (i > 0) @(negedge clk);
      if (frame_start === 1'b1) m_fs++;
      for (int k = 0; k < int'(NS); k++) begin
        if (pwm[k] === 1'b1) begin
          m_cnt[k]++;
          if (m_first[k] < 0) m_first[k] = i;
        end
      end
      if ($countones(pwm) > 1) m_overlap++;
    end
  endtask

  task automatic test_reset();
    bus.servos     = '0;
    bus.servos_stb = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pwm !== '0 || frame_start !== 1'b0 || bad_cmd_count !== 8'd0 || bus.servos_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got pwm=%b fs=%b bad=%0d ack=%b exp all zero",
               pwm, frame_start, bad_cmd_count, bus.servos_ack);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle();
    int pwm_hi, ack_hi, fs_bad, fs_cnt;
    pwm_hi = 0; ack_hi = 0; fs_bad = 0; fs_cnt = 0;
    for (int n = 1; n <= 3 * int'(FRAME_CYC); n++) begin
      @(negedge clk);
      if (pwm !== '0) pwm_hi++;
      if (bus.servos_ack !== 1'b0) ack_hi++;
      if (frame_start === 1'b1) fs_cnt++;
      if (frame_start !== ((n % int'(FRAME_CYC)) == 0)) fs_bad++;
    end
    checks++;
    if (pwm_hi !== 0) begin
      failures++;
      $display("FAIL idle_pwm high_cycles got=%0d exp=0", pwm_hi);
    end
    checks++;
    if (ack_hi !== 0) begin
      failures++;
      $display("FAIL idle_ack ack_cycles got=%0d exp=0", ack_hi);
    end
    checks++;
    if (fs_bad !== 0 || fs_cnt !== 3) begin
      failures++;
      $display("FAIL idle_frame_start misplaced=%0d count=%0d exp misplaced=0 count=3", fs_bad, fs_cnt);
    end
  endtask

  task automatic test_cmd();
    send_cmd(16'h1020, "cmd_ch1");
    measure(1'b1);
    checks++;
    if (m_cnt[1] !== 64 || m_first[1] !== int'(1 + 2 * OFS)) begin
      failures++;
      $display("FAIL cmd_ch1_pulse got cnt=%0d first=%0d exp cnt=64 first=%0d", m_cnt[1], m_first[1], 1 + 2 * OFS);
    end
    checks++;
    if (m_cnt[0] !== 0 || m_cnt[2] !== 0 || m_cnt[3] !== 0) begin
      failures++;
      $display("FAIL cmd_other_channels got %0d/%0d/%0d exp 0/0/0", m_cnt[0], m_cnt[2], m_cnt[3]);
    end
    checks++;
    if (m_fs !== 1) begin
      failures++;
      $display("FAIL cmd_frame_start_count got=%0d exp=1", m_fs);
    end
  endtask

  task automatic test_clamp();
    send_cmd(16'h0005, "clamp_min");
    measure(1'b1);
    checks++;
    if (m_cnt[0] !== int'(2 * MINP) || m_first[0] !== 1) begin
      failures++;
      $display("FAIL clamp_min got cnt=%0d first=%0d exp cnt=%0d first=1", m_cnt[0], m_first[0], 2 * MINP);
    end
    send_cmd(16'h0FFF, "clamp_max");
    measure(1'b1);
    checks++;
    if (m_cnt[0] !== int'(2 * MAXP)) begin
      failures++;
      $display("FAIL clamp_max got cnt=%0d exp=%0d", m_cnt[0], 2 * MAXP);
    end
    checks++;
    if (m_cnt[1] !== 64) begin
      failures++;
      $display("FAIL clamp_ch1_kept got=%0d exp=64", m_cnt[1]);
    end
    send_cmd(16'h0000, "clamp_zero");
    measure(1'b1);
    checks++;
    if (m_cnt[0] !== 0) begin
      failures++;
      $display("FAIL clamp_zero_disable got=%0d exp=0", m_cnt[0]);
    end
  endtask

  task automatic test_bad_channel();
    send_cmd(16'h5010, "bad_ch5");
    checks++;
    if (bad_cmd_count !== 8'd1) begin
      failures++;
      $display("FAIL bad_count_first got=%0d exp=1", bad_cmd_count);
    end
    measure(1'b1);
    checks++;
    if (m_cnt[0] !== 0 || m_cnt[1] !== 64 || m_cnt[2] !== 0 || m_cnt[3] !== 0) begin
      failures++;
      $display("FAIL bad_no_pwm_change got %0d/%0d/%0d/%0d exp 0/64/0/0", m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
    end
    for (int i = 0; i < 10; i++) send_cmd(16'hF123, "bad_burst");
    checks++;
    if (bad_cmd_count !== 8'd11) begin
      failures++;
      $display("FAIL bad_count_11 got=%0d exp=11", bad_cmd_count);
    end
    for (int i = 0; i < 290; i++) send_cmd(16'h4ABC, "bad_burst");
    checks++;
    if (bad_cmd_count !== 8'd255) begin
      failures++;
      $display("FAIL bad_count_saturate got=%0d exp=255", bad_cmd_count);
    end
  endtask

  task automatic test_frame_edge();
    wait_fs();
    repeat (int'(FRAME_CYC) - 1) @(negedge clk);
    bus.servos     = 16'h2014;
    bus.servos_stb = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.servos_ack !== 1'b1 || frame_start !== 1'b1) begin
      failures++;
      $display("FAIL edge_align got ack=%b fs=%b exp ack=1 fs=1", bus.servos_ack, frame_start);
    end
    bus.servos_stb = 1'b0;
    @(negedge clk);
    measure(1'b0);
    checks++;
    if (m_cnt[2] !== 0) begin
      failures++;
      $display("FAIL edge_same_frame got=%0d exp=0", m_cnt[2]);
    end
    measure(1'b1);
    checks++;
    if (m_cnt[2] !== 40 || m_first[2] !== int'(1 + 4 * OFS)) begin
      failures++;
      $display("FAIL edge_next_frame got cnt=%0d first=%0d exp cnt=40 first=%0d", m_cnt[2], m_first[2], 1 + 4 * OFS);
    end
  endtask

  task automatic test_reset_mid_pulse();
    wait_fs();
    repeat (50) @(negedge clk);
    checks++;
    if (pwm[1] !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre_high got=%b exp=1", pwm[1]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (pwm !== '0) begin
      failures++;
      $display("FAIL midrst_async_low got=%b exp=0", pwm);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    measure(1'b1);
    checks++;
    if (m_cnt[0] !== 0 || m_cnt[1] !== 0 || m_cnt[2] !== 0 || m_cnt[3] !== 0 || bad_cmd_count !== 8'd0) begin
      failures++;
      $display("FAIL midrst_disabled got %0d/%0d/%0d/%0d bad=%0d exp 0/0/0/0 bad=0",
               m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3], bad_cmd_count);
    end
  endtask

`ifdef SERVO_STAGGER_EN
  task automatic test_stagger();
    send_cmd(16'h000A, "stag_ch0");
    send_cmd(16'h100A, "stag_ch1");
    send_cmd(16'h200A, "stag_ch2");
    send_cmd(16'h300A, "stag_ch3");
    measure(1'b1);
    for (int k = 0; k < int'(NS); k++) begin
      checks++;
      if (m_cnt[k] !== 20 || m_first[k] !== 1 + 2 * k * int'(STG)) begin
        failures++;
        $display("FAIL stagger_ch%0d got cnt=%0d first=%0d exp cnt=20 first=%0d",
                 k, m_cnt[k], m_first[k], 1 + 2 * k * int'(STG));
      end
    end
    checks++;
    if (m_overlap !== 0) begin
      failures++;
      $display("FAIL stagger_overlap got=%0d exp=0", m_overlap);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_cmd();
    test_clamp();
    test_bad_channel();
    test_frame_edge();
    test_reset_mid_pulse();
`ifdef SERVO_STAGGER_EN
    test_stagger();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
